// File: rtl/frag_fb_writer_pkg.sv
// Shared rasterizer types: fragments, pixels and framebuffer writer state.
// Imported by the fragment framebuffer writer and its address generator.
package frag_fb_writer_pkg;

  localparam int FB_BYTES_PER_PIXEL = 4;

  typedef logic [31:0] rgba8888_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } fragment_t;

  typedef logic [1:0] fbw_state_t;

  localparam fbw_state_t S_IDLE = 2'd0;
  localparam fbw_state_t S_ADDR = 2'd1;
  localparam fbw_state_t S_REQ  = 2'd2;
  localparam fbw_state_t S_DONE = 2'd3;

endpackage

// File: rtl/frag_fb_writer_if.sv
// Fragment queue and memory write port bundle of the framebuffer writer.
// master = writer side, slave = generator/memory side.
interface frag_fb_writer_if;
  import frag_fb_writer_pkg::*;

  logic        frag_val;
  fragment_t   frag;
  logic        pop_frag;
  logic        gen_done;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  rgba8888_t   mem_req_data;
  logic        mem_req_ready;

  modport master (
    input  frag_val,
    input  frag,
    input  gen_done,
    input  mem_req_ready,
    output pop_frag,
    output mem_req_valid,
    output mem_req_addr,
    output mem_req_data
  );

  modport slave (
    output frag_val,
    output frag,
    output gen_done,
    output mem_req_ready,
    input  pop_frag,
    input  mem_req_valid,
    input  mem_req_addr,
    input  mem_req_data
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Registered framebuffer clip test and pixel byte-address multiply-add.
// Captures on i_load; results are valid the following cycle and held.
module fb_addr_gen
  import frag_fb_writer_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic [31:0] i_base,
  output logic        o_clip,
  output logic [31:0] o_addr
);

  logic [31:0] w_lin;
  logic [31:0] w_addr;
  logic        w_clip;
  logic        r_clip;
  logic [31:0] r_addr;

  // Everything is modulo 2^32; overflow is intentionally unflagged.
  assign w_lin  = i_y * 32'(FB_WIDTH) + i_x;
  assign w_addr = i_base + w_lin * 32'(FB_BYTES_PER_PIXEL);
  assign w_clip = (i_x >= 32'(FB_WIDTH)) ||
                  (i_y >= 32'(FB_HEIGHT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip <= 1'b0;
      r_addr <= '0;
    end else if (i_load) begin
      r_clip <= w_clip;
      r_addr <= w_addr;
    end
  end

  assign o_clip = r_clip;
  assign o_addr = r_addr;

endmodule

// File: rtl/frag_fb_writer.sv
// Drains the fragment queue, clips to the framebuffer and issues one
// colour write per surviving fragment; pulses done once all are retired.
module frag_fb_writer
  import frag_fb_writer_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  rgba8888_t        tri_color,
  input  logic [31:0]      fb_base,
  frag_fb_writer_if.master bus,
  output logic [31:0]      frag_count,
  output logic [31:0]      clip_count,
  output logic             done
);

  fbw_state_t  r_state;
  fbw_state_t  w_next;
  rgba8888_t   r_color;
  logic [31:0] r_base;
  rgba8888_t   r_data;
  logic        r_gdone;
  logic [31:0] r_frag_cnt;
  logic [31:0] r_clip_cnt;

  logic        w_pop;
  logic        w_accept;
  logic        w_clip_evt;
  logic        w_clip;
  logic [31:0] w_addr;
  logic        w_unused;

  // Gated by rst so nothing is dequeued while reset is held.
  assign w_pop      = (r_state == S_IDLE) && bus.frag_val && !rst;
  assign w_accept   = (r_state == S_REQ) && bus.mem_req_ready;
  assign w_clip_evt = (r_state == S_ADDR) && w_clip;
  assign w_unused   = ^{bus.frag.w0, bus.frag.w1, bus.frag.w2};

  fb_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pop),
    .i_x    (bus.frag.x),
    .i_y    (bus.frag.y),
    .i_base (r_base),
    .o_clip (w_clip),
    .o_addr (w_addr)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.frag_val)
          w_next = S_ADDR;
        else if (r_gdone)
          w_next = S_DONE;
      end
      S_ADDR:  w_next = w_clip ? S_IDLE : S_REQ;
      S_REQ: begin
        if (bus.mem_req_ready)
          w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_color <= '0;
      r_base  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (start) begin
        r_color <= tri_color;
        r_base  <= fb_base;
      end
      // Payload is frozen on entry to REQ so a start cannot disturb it.
      if (r_state == S_ADDR)
        r_data <= r_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_gdone <= 1'b0;
    else if (bus.gen_done)
      r_gdone <= 1'b1;
    else if (start || (r_state == S_DONE))
      r_gdone <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frag_cnt <= '0;
      r_clip_cnt <= '0;
    end else if (start) begin
      r_frag_cnt <= {31'b0, w_accept};
      r_clip_cnt <= {31'b0, w_clip_evt};
    end else begin
      if (w_accept)
        r_frag_cnt <= r_frag_cnt + 32'd1;
      if (w_clip_evt)
        r_clip_cnt <= r_clip_cnt + 32'd1;
    end
  end

  assign bus.pop_frag      = w_pop;
  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = w_addr;
  assign bus.mem_req_data  = r_data;
  assign frag_count        = r_frag_cnt;
  assign clip_count        = r_clip_cnt;
  assign done              = (r_state == S_DONE);

endmodule

// File: tb/tb_frag_fb_writer.sv
// Bench for frag_fb_writer: queue-fed fragments, scoreboarded writes.
// Reference addresses come from 64-bit pixel arithmetic truncated to 32.
module tb_frag_fb_writer;
  import frag_fb_writer_pkg::*;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  rgba8888_t   tri_color;
  logic [31:0] fb_base;
  logic [31:0] frag_count;
  logic [31:0] clip_count;
  logic        done;

  frag_fb_writer_if bus();

  frag_fb_writer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tri_color  (tri_color),
    .fb_base    (fb_base),
    .bus        (bus.master),
    .frag_count (frag_count),
    .clip_count (clip_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fragment_t   fq[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          pop_cyc[$];
  int          acc_cyc[$];
  int          model_clips = 0;
  logic [31:0] m_base = '0;
  rgba8888_t   m_color = '0;

  int          cyc = 0;
  int          valid_rise = -1;
  int          valid_samples = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          bad_pop = 0;
  int          stall_viol = 0;
  logic        p_stall = 1'b0;
  logic        p_val = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_data = '0;

  function automatic logic [31:0] exp_addr(
    input logic [31:0] b, input logic [31:0] x,
    input logic [31:0] y);
    logic [63:0] t;
    t = ({32'b0, y} * 64'(W) + {32'b0, x}) * 64'd4 + {32'b0, b};
    return t[31:0];
  endfunction

  task automatic drive_q();
    bus.frag_val = (fq.size() != 0);
    bus.frag     = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y);
    fragment_t f;
    f.x  = x;
    f.y  = y;
    f.w0 = $urandom;
    f.w1 = $urandom;
    f.w2 = $urandom;
    fq.push_back(f);
    if (x >= 32'(W) || y >= 32'(H))
      model_clips++;
    else
      exp_q.push_back({exp_addr(m_base, x, y), m_color});
    drive_q();
  endtask

  task automatic tick();
    logic pop, val, rdy;
    logic [31:0] a, d;
    #2;
    pop = bus.pop_frag;
    val = bus.mem_req_valid;
    rdy = bus.mem_req_ready;
    a   = bus.mem_req_addr;
    d   = bus.mem_req_data;
    if (pop && !bus.frag_val) bad_pop++;
    if (p_stall && (!val || a !== p_addr || d !== p_data))
      stall_viol++;
    p_stall = val && !rdy;
    p_addr  = a;
    p_data  = d;
    if (val) valid_samples++;
    if (val && !p_val) valid_rise = cyc;
    p_val = val;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (pop) begin
      void'(fq.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (val && rdy) begin
      got_q.push_back({a, d});
      acc_cyc.push_back(cyc);
    end
    cyc++;
    drive_q();
  endtask

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
    acc_cyc.delete();
    model_clips   = 0;
    valid_rise    = -1;
    valid_samples = 0;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] col);
    clear_logs();
    start     = 1'b1;
    fb_base   = base;
    tri_color = col;
    m_base    = base;
    m_color   = col;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 2000) begin
      tick();
      n++;
      if (fq.size() == 0 && !bus.mem_req_valid) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL drain_timeout: quiet=%0d required 4", quiet);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tri_color = '0;
    fb_base = '0;
    bus.gen_done = 1'b0;
    bus.mem_req_ready = 1'b0;
    clear_logs();
    push(32'd5, 32'd1);
    repeat (3) tick();
    checks++;
    if (bus.pop_frag !== 1'b0) begin
      errors++;
      $display("FAIL rst_pop: got %b required 0", bus.pop_frag);
    end
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b required 0", bus.mem_req_valid);
    end
    checks++;
    if (bus.mem_req_addr !== 32'd0 || bus.mem_req_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_payload: got %h/%h required 0/0",
               bus.mem_req_addr, bus.mem_req_data);
    end
    checks++;
    if (frag_count !== 32'd0 || clip_count !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_counts: got %0d/%0d/%b required 0/0/0",
               frag_count, clip_count, done);
    end
    checks++;
    if (pop_cyc.size() !== 0) begin
      errors++;
      $display("FAIL rst_no_pop: got %0d pops required 0", pop_cyc.size());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pop_cyc.size() !== 1) begin
      errors++;
      $display("FAIL rst_first_pop: got %0d pops required 1", pop_cyc.size());
    end
    bus.mem_req_ready = 1'b1;
    drain();
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== {32'h0000_0A14, 32'h0}) begin
      errors++;
      $display("FAIL rst_first_write: got n=%0d required 1 write to 00000a14",
               got_q.size());
    end
  endtask

  task automatic test_basic();
    bus.mem_req_ready = 1'b1;
    do_start(32'h0000_1000, $urandom);
    push(32'd3, 32'd2);
    drain();
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL basic_n: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0][63:32] !== 32'h0000_240C) begin
        errors++;
        $display("FAIL basic_addr: got %h required 0000240c", got_q[0][63:32]);
      end
      checks++;
      if (got_q[0][31:0] !== m_color) begin
        errors++;
        $display("FAIL basic_data: got %h required %h", got_q[0][31:0], m_color);
      end
    end
    checks++;
    if (frag_count !== 32'd1) begin
      errors++;
      $display("FAIL basic_count: got %0d required 1", frag_count);
    end
    checks++;
    if (pop_cyc.size() !== 1 || valid_rise - pop_cyc[0] !== 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 2",
               valid_rise - ((pop_cyc.size() != 0) ? pop_cyc[0] : 0));
    end
  endtask

  task automatic test_clip();
    bus.mem_req_ready = 1'b1;
    do_start($urandom, $urandom);
    push(32'd640, 32'd0);
    push(32'd0, 32'd480);
    drain();
    checks++;
    if (valid_samples !== 0) begin
      errors++;
      $display("FAIL clip_valid: got %0d valid cycles required 0", valid_samples);
    end
    checks++;
    if (clip_count !== 32'd2 || frag_count !== 32'd0) begin
      errors++;
      $display("FAIL clip_counts: got clip=%0d frag=%0d required 2/0",
               clip_count, frag_count);
    end
    checks++;
    if (pop_cyc.size() !== 2 || pop_cyc[1] - pop_cyc[0] !== 2) begin
      errors++;
      $display("FAIL clip_spacing: got %0d pops required 2 pops 2 apart",
               pop_cyc.size());
    end
  endtask

  task automatic test_stall();
    logic [31:0] a0, d0;
    int n = 0;
    int npop;
    bus.mem_req_ready = 1'b0;
    do_start($urandom, $urandom);
    push($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    push($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    while (!bus.mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.mem_req_valid) begin
      errors++;
      $display("FAIL stall_no_valid: got 0 required 1");
    end
    a0 = bus.mem_req_addr;
    d0 = bus.mem_req_data;
    npop = pop_cyc.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a0 ||
          bus.mem_req_data !== d0) begin
        errors++;
        $display("FAIL stall_hold%0d: got %b %h %h required 1 %h %h",
                 i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data,
                 a0, d0);
      end
    end
    checks++;
    if (pop_cyc.size() !== npop || frag_count !== 32'd0) begin
      errors++;
      $display("FAIL stall_pop: got pops=%0d count=%0d required %0d/0",
               pop_cyc.size(), frag_count, npop);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    checks++;
    if (frag_count !== 32'd1) begin
      errors++;
      $display("FAIL stall_count: got %0d required 1", frag_count);
    end
    drain();
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL stall_writes: got n=%0d required 2 matching", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bus.mem_req_ready = 1'b1;
    do_start($urandom, $urandom);
    for (int i = 0; i < 4; i++)
      push($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    drain();
    checks++;
    if (got_q.size() !== 4) begin
      errors++;
      $display("FAIL b2b_n: got %0d required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (pop_cyc.size() !== 4) begin
      errors++;
      $display("FAIL b2b_pops: got %0d required 4", pop_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (pop_cyc[i] - pop_cyc[i-1] !== 3) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d required 3", i,
                   pop_cyc[i] - pop_cyc[i-1]);
        end
      end
    end
    checks++;
    if (frag_count !== 32'd4) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 4", frag_count);
    end
  endtask

  task automatic test_done();
    int n = 0;
    int d0;
    bus.mem_req_ready = 1'b0;
    do_start($urandom, $urandom);
    push($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    push($urandom_range(0, W - 1), $urandom_range(0, H - 1));
    while (!bus.mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    d0 = done_cnt;
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    bus.mem_req_ready = 1'b1;
    drain();
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL done_once: got %0d pulses required 1", done_cnt - d0);
    end
    checks++;
    if (acc_cyc.size() !== 2 || done_cyc <= acc_cyc[acc_cyc.size() - 1]) begin
      errors++;
      $display("FAIL done_order: got done@%0d, %0d writes required after 2 writes",
               done_cyc, acc_cyc.size());
    end
    checks++;
    if (frag_count !== 32'd2 || got_q.size() !== 2 ||
        got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL done_writes: got count=%0d n=%0d required 2 matching",
               frag_count, got_q.size());
    end
    start = 1'b1;
    bus.gen_done = 1'b1;
    tick();
    start = 1'b0;
    bus.gen_done = 1'b0;
    checks++;
    if (frag_count !== 32'd0 || clip_count !== 32'd0) begin
      errors++;
      $display("FAIL start_clear: got %0d/%0d required 0/0", frag_count, clip_count);
    end
    d0 = done_cnt;
    repeat (4) tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL start_gen_done: got %0d pulses required 1", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int n = 0;
    logic [31:0] x, y;
    do_start(32'hFFFF_F000, $urandom);
    while ((pushed < 40 || fq.size() != 0 || bus.mem_req_valid) && n < 5000) begin
      if (pushed < 40 && $urandom_range(0, 2) == 0) begin
        x = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, W + 20);
        y = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, H + 20);
        push(x, y);
        pushed++;
      end
      bus.mem_req_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.mem_req_ready = 1'b1;
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rnd_n: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd_write%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (clip_count !== 32'(model_clips) || frag_count !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL rnd_counts: got clip=%0d frag=%0d required %0d/%0d",
               clip_count, frag_count, model_clips, exp_q.size());
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL rnd_stall_rule: got %0d violations required 0", stall_viol);
    end
    checks++;
    if (bad_pop !== 0) begin
      errors++;
      $display("FAIL rnd_pop_rule: got %0d bad pops required 0", bad_pop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_back_to_back();
    test_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
